// File: rtl/rvm_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvm_div_unit_pkg
// Description : Shared encodings for the RV32M iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package rvm_div_unit_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

endpackage : rvm_div_unit_pkg
`default_nettype wire

// File: rtl/rvm_div_step.sv
`default_nettype none
// ============================================================================
// Module      : rvm_div_step
// Description : One radix-2 restoring division step (shift, trial subtract).
// Revision    : 1.0 - initial release
// ============================================================================
module rvm_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] remNext,
    output logic [XLEN-1:0] quoNext
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_trial;

    // Borrow out of the XLEN+1-bit subtract means the trial failed and the
    // shifted remainder is restored.
    always_comb begin
        w_shifted = {rem, quo[XLEN-1]};
        w_trial   = w_shifted - {1'b0, divisor};
        remNext   = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
        quoNext   = {quo[XLEN-2:0], ~w_trial[XLEN]};
    end

endmodule : rvm_div_step
`default_nettype wire

// File: rtl/rvm_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : rvm_div_unit
// Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2.
// Revision    : 1.0 - initial release
// ============================================================================
module rvm_div_unit
    import rvm_div_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            DivStart,
    input  logic [1:0]      DivOp,
    input  logic [XLEN-1:0] Dividend,
    input  logic [XLEN-1:0] Divisor,
    input  logic            Flush,
    output logic [XLEN-1:0] DivResult,
    output logic            DivHoldEnd,
    output logic            DivBusy
);

    divState_t       r_state;
    divState_t       w_nextState;
    logic [CNTW-1:0] r_count;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_result;
    logic [1:0]      r_op;
    logic            r_negQ;
    logic            r_negR;

    logic            w_isSigned;
    logic            w_aNeg;
    logic            w_bNeg;
    logic [XLEN-1:0] w_aMag;
    logic [XLEN-1:0] w_bMag;
    logic            w_divZero;
    logic            w_overflow;
    logic            w_accept;
    logic            w_lastStep;
    logic [XLEN-1:0] w_stepRem;
    logic [XLEN-1:0] w_stepQuo;
    logic [XLEN-1:0] w_fixResult;

    always_comb begin
        w_isSigned = (DivOp == DIV_OP_DIV) || (DivOp == DIV_OP_REM);
        w_aNeg     = w_isSigned & Dividend[XLEN-1];
        w_bNeg     = w_isSigned & Divisor[XLEN-1];
        w_aMag     = w_aNeg ? (~Dividend + 1'b1) : Dividend;
        w_bMag     = w_bNeg ? (~Divisor + 1'b1) : Divisor;
        w_divZero  = (Divisor == '0);
        w_overflow = w_isSigned && (Dividend == {1'b1, {(XLEN-1){1'b0}}}) && (Divisor == '1);
        w_accept   = (r_state == DIV_IDLE) && DivStart && !Flush;
        w_lastStep = (r_count == CNTW'(1));
    end

    rvm_div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .divisor (r_divisor),
        .remNext (w_stepRem),
        .quoNext (w_stepQuo)
    );

    always_comb begin
        case (r_op)
            DIV_OP_DIV:  w_fixResult = r_negQ ? (~w_stepQuo + 1'b1) : w_stepQuo;
            DIV_OP_DIVU: w_fixResult = w_stepQuo;
            DIV_OP_REM:  w_fixResult = r_negR ? (~w_stepRem + 1'b1) : w_stepRem;
            DIV_OP_REMU: w_fixResult = w_stepRem;
            default:     w_fixResult = w_stepQuo;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        DivHoldEnd  = 1'b0;
        DivBusy     = (r_state != DIV_IDLE);
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_nextState = (w_divZero || w_overflow) ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (Flush) begin
                    w_nextState = DIV_IDLE;
                end else if (w_lastStep) begin
                    w_nextState = DIV_DONE;
                end
            end
            DIV_DONE: begin
                DivHoldEnd  = !Flush;
                w_nextState = DIV_IDLE;
            end
            default: w_nextState = DIV_IDLE;
        endcase
    end

    // The result register is loaded on the edge that enters DONE, so it is
    // already valid during the hold-end cycle and persists afterwards.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
            r_op      <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
        end else if (w_accept) begin
            r_op      <= DivOp;
            r_negQ    <= w_aNeg ^ w_bNeg;
            r_negR    <= w_aNeg;
            r_count   <= CNTW'(XLEN);
            r_rem     <= '0;
            r_quo     <= w_aMag;
            r_divisor <= w_bMag;
            if (w_divZero) begin
                r_result <= DivOp[1] ? Dividend : '1;
            end else if (w_overflow) begin
                r_result <= DivOp[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if ((r_state == DIV_CALC) && !Flush) begin
            r_rem   <= w_stepRem;
            r_quo   <= w_stepQuo;
            r_count <= r_count - 1'b1;
            if (w_lastStep) begin
                r_result <= w_fixResult;
            end
        end
    end

    assign DivResult = r_result;

endmodule : rvm_div_unit
`default_nettype wire

// File: tb/tb_rvm_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvm_div_unit
// Description : Scoreboard bench for rvm_div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvm_div_unit;

    localparam int XLEN = 32;

    logic            Clk = 1'b0;
    logic            Rst;
    logic            DivStart;
    logic [1:0]      DivOp;
    logic [XLEN-1:0] Dividend;
    logic [XLEN-1:0] Divisor;
    logic            Flush;
    logic [XLEN-1:0] DivResult;
    logic            DivHoldEnd;
    logic            DivBusy;

    rvm_div_unit #(
        .XLEN (XLEN),
        .CNTW (6)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .DivStart   (DivStart),
        .DivOp      (DivOp),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .Flush      (Flush),
        .DivResult  (DivResult),
        .DivHoldEnd (DivHoldEnd),
        .DivBusy    (DivBusy)
    );

    always #5 Clk = ~Clk;

    int cycleCnt = 0;
    always @(posedge Clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: RISC-V M semantics from plain integer arithmetic.
    function automatic logic [XLEN-1:0] refDiv(input logic [1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        longint          sa;
        longint          sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = XLEN'(sa / sb);
            r  = XLEN'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every hold-end pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Rst && DivHoldEnd) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got result %h at cycle %0d expected no completion", DivResult, cycleCnt);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (DivResult !== e.res) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", DivResult, e.res);
                end
                checks++;
                if (cycleCnt != e.cyc) begin
                    errors++;
                    $display("FAIL latency: got cycle %0d expected cycle %0d", cycleCnt, e.cyc);
                end
            end
        end
    end

    task automatic startOp(input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input bit doPush);
        int   c0;
        exp_t e;
        bit   special;
        @(posedge Clk);
        #1;
        DivStart = 1'b1;
        DivOp    = op;
        Dividend = a;
        Divisor  = b;
        @(posedge Clk);
        #1;
        c0       = cycleCnt;
        DivStart = 1'b0;
        special  = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (doPush) begin
            e.res = refDiv(op, a, b);
            e.cyc = special ? c0 : c0 + XLEN;
            sbq.push_back(e);
        end
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clk);
            if (DivHoldEnd) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no DivHoldEnd within 60 cycles expected a completion");
        end
    endtask

    initial begin
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        int              sel;

        Rst      = 1'b1;
        DivStart = 1'b0;
        DivOp    = '0;
        Dividend = '0;
        Divisor  = '0;
        Flush    = 1'b0;
        #2;
        check("reset_result", DivResult, '0);
        check("reset_holdend", {31'b0, DivHoldEnd}, '0);
        check("reset_busy", {31'b0, DivBusy}, '0);
        @(posedge Clk);
        #1 Rst = 1'b0;

        // Directed cases, issued back-to-back after each completion.
        startOp(2'b01, 32'd100, 32'd7, 1'b1);
        @(negedge Clk);
        check("busy_calc", {31'b0, DivBusy}, 32'd1);
        waitDone();
        startOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);         waitDone();
        startOp(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);         waitDone();
        startOp(2'b00, 32'd5, 32'd0, 1'b1);                 waitDone();
        startOp(2'b11, 32'd5, 32'd0, 1'b1);                 waitDone();
        startOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone();
        startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); waitDone();

        // Flush abort: no completion may follow.
        startOp(2'b01, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        check("flush_busy", {31'b0, DivBusy}, '0);
        repeat (40) @(posedge Clk);
        startOp(2'b01, 32'd9, 32'd3, 1'b1);                 waitDone();

        // Start while busy is ignored.
        startOp(2'b01, 32'd100, 32'd7, 1'b1);
        repeat (5) @(posedge Clk);
        #1;
        DivStart = 1'b1;
        DivOp    = 2'b11;
        Dividend = 32'd50;
        Divisor  = 32'd6;
        @(posedge Clk);
        #1 DivStart = 1'b0;
        waitDone();
        repeat (3) @(negedge Clk);
        check("result_holds", DivResult, 32'd14);

        // Asynchronous reset mid-calculation.
        startOp(2'b01, 32'd1000, 32'd3, 1'b0);
        repeat (5) @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        check("async_rst_result", DivResult, '0);
        check("async_rst_busy", {31'b0, DivBusy}, '0);
        check("async_rst_holdend", {31'b0, DivHoldEnd}, '0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        startOp(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);         waitDone();

        // Randomized operations.
        for (int n = 0; n < 30; n++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = '0;
            else if (sel < 3)  b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            else if (sel == 4) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else               b = $urandom;
            if (sel == 5) a = 32'($urandom_range(0, 200));
            startOp(op, a, b, 1'b1);
            waitDone();
        end

        repeat (5) @(posedge Clk);
        check("scoreboard_empty", 32'(sbq.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rvm_div_unit
`default_nettype wire
